// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with occupancy/threshold flags and
// registered overflow/underflow pulses. Full/empty are derived from a stored count.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     wr_error,
  output logic                     rd_error,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeCnt    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_error_q, wr_error_d;
  logic             rd_error_q, rd_error_d;

  logic             full_s, empty_s;
  logic             wr_accept, rd_accept;

  assign full_s  = (count_q == DepthCnt);
  assign empty_s = (count_q == '0);

  // Acceptance looks only at pre-edge flags, so a read on a full FIFO
  // does not make room for a same-edge write.
  assign wr_accept = wr_en && !clear && !full_s;
  assign rd_accept = rd_en && !clear && !empty_s;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    wr_error_d = 1'b0;
    rd_error_d = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_error_d = wr_en && full_s;
      rd_error_d = rd_en && empty_s;
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rdata_d  = mem_q[rd_ptr_q];
      end
      count_d = count_q + CW'(wr_accept) - CW'(rd_accept);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      wr_error_q <= wr_error_d;
      rd_error_q <= rd_error_d;
    end
  end

  // Storage is never reset; count gating keeps stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata        = rdata_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= AfCnt);
  assign almost_empty = (count_q <= AeCnt);
  assign wr_error     = wr_error_q;
  assign rd_error     = rd_error_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised + directed bench for fifo_sync_param against a queue-based model.
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, clear, wr_en, rd_en;
  logic [W-1:0]  wdata, rdata;
  logic          full, empty, almost_full, almost_empty, wr_error, rd_error;
  logic [CW-1:0] count;

  fifo_sync_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_error     (wr_error),
    .rd_error     (rd_error),
    .count        (count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata;
  logic         m_werr, m_rerr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("count", 32'(count), 32'(n));
    check_eq("full", 32'(full), 32'(n == D));
    check_eq("empty", 32'(empty), 32'(n == 0));
    check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
    check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check_eq("wr_error", 32'(wr_error), 32'(m_werr));
    check_eq("rd_error", 32'(rd_error), 32'(m_rerr));
    check_eq("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  // Drive at negedge, apply one rising edge, update model, check 1ns later.
  task automatic step(input logic w, input logic [W-1:0] wd, input logic r, input logic c);
    bit was_full, was_empty;
    wr_en = w;
    wdata = wd;
    rd_en = r;
    clear = c;
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else begin
      m_werr = w && was_full;
      m_rerr = r && was_empty;
      if (r && !was_empty) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(wd);
    end
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q.delete();
    m_rdata = '0;
    m_werr  = 1'b0;
    m_rerr  = 1'b0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pw, pr;
    rst   = 1'b0;
    clear = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    m_rdata = '0;
    m_werr  = 1'b0;
    m_rerr  = 1'b0;
    @(negedge clk);
    do_reset();

    // Fill 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    check_eq("full_after_8", 32'(full), 32'd1);
    // Overflow with 0xAA, held two cycles, then one idle to see the pulse drop.
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    // Full with simultaneous wr/rd: read wins, write rejected.
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    check_eq("count_full_both", 32'(count), 32'd7);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    // Underflow then empty with simultaneous wr/rd.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h5C, 1'b1, 1'b0);
    check_eq("count_empty_both", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap at steady occupancy 4, then fill past AF and drain past AE.
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, W'(8'h30 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, W'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Clear at count 5, then new data round-trips.
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    step(1'b1, 8'h71, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    // Asynchronous reset at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
    #2;
    do_reset();
    step(1'b1, 8'h91, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic, alternating fill-biased and drain-biased blocks.
    for (int i = 0; i < 3000; i++) begin
      if (((i / 150) % 2) == 0) begin
        pw = 75;
        pr = 35;
      end else begin
        pw = 35;
        pr = 75;
      end
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < pr,
             $urandom_range(0, 127) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width in bits, legal range 1..256.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of entries, a power of two, legal range 4..1024.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold, legal range 1..DEPTH-1.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: almost_empty threshold, legal range 1..DEPTH-1.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous flush.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-010 The block SHALL have port wdata, input, WIDTH bits: write data.
REQ-011 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-012 The block SHALL have port rdata, output, WIDTH bits: read data.
REQ-013 The block SHALL have ports full and empty, output, 1 bit each: occupancy flags.
REQ-014 The block SHALL have ports almost_full and almost_empty, output, 1 bit each: threshold flags.
REQ-015 The block SHALL have ports wr_error and rd_error, output, 1 bit each: overflow and underflow pulses.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.

Function
REQ-017 The block SHALL accept a write at a clk edge when wr_en=1, clear=0 and full=1 is not true before that edge.
REQ-018 The block SHALL accept a read at a clk edge when rd_en=1, clear=0 and empty=1 is not true before that edge.
REQ-019 When full, with wr_en=1 and rd_en=1 on the same edge, the block SHALL accept the read, reject the write, and pulse wr_error.
REQ-020 When empty, with wr_en=1 and rd_en=1 on the same edge, the block SHALL accept the write, reject the read, and pulse rd_error.
REQ-021 When neither full nor empty, a simultaneous write and read SHALL both be accepted and count SHALL remain unchanged.
REQ-022 count SHALL be updated at each edge as count + accepted_write - accepted_read; it SHALL never exceed DEPTH or drop below 0.
REQ-023 The pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by count, or by an extra pointer bit, never by pointer equality alone.
REQ-024 rdata SHALL present the oldest entry registered on the edge that accepts the read (latency 1), and SHALL hold its value on all other edges.
REQ-025 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both driven from registered state only.
REQ-026 almost_full SHALL equal (count>=AF_LEVEL) and almost_empty SHALL equal (count<=AE_LEVEL).
REQ-027 wr_error and rd_error SHALL be registered, SHALL be high for exactly the one cycle after a rejected request, and SHALL NOT be sticky.
REQ-028 Repeated rejected requests SHALL hold the corresponding error flag high on each following cycle.
REQ-029 clear=1 SHALL take priority over wr_en and rd_en: pointers and count go to 0, errors go to 0, and rdata holds its value.
REQ-030 Memory contents SHALL NOT require reset; a read SHALL never return an entry that was not written since the last reset or clear.

Reset
REQ-031 While rst=1, the block SHALL force, asynchronously: count=0, empty=1, almost_empty=1, full=0, almost_full=0, wr_error=0, rd_error=0, rdata=0, and pointers=0.
REQ-032 When rst is asserted mid-operation, all in-flight data SHALL be discarded.
REQ-033 The first write SHALL be accepted on the first clk edge after rst deasserts.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-034 Scenario: write 0x01..0x08 back-to-back, then read 8 times -> full=1 after the 8th write; rdata=0x01..0x08 in order, one cycle after each read; empty=1 at the end.
REQ-035 Scenario: full FIFO plus wr_en=1 with wdata=0xAA -> wr_error pulses for 1 cycle, count stays 8, and 0xAA is never read.
REQ-036 Scenario: empty FIFO plus rd_en=1 -> rd_error pulses for 1 cycle, and rdata and count are unchanged.
REQ-037 Scenario: count=8 with simultaneous wr_en=1 and rd_en=1 -> count=7 and wr_error=1; count=0 with both asserted -> count=1 and rd_error=1.
REQ-038 Scenario: 12 writes interleaved with reads at count=4 (pointer wrap) -> data order preserved; almost_full toggles at count 6, and almost_empty at count 2.
REQ-039 Scenario: rst or clear asserted at count=5 -> count=0 and empty=1 (immediately for rst, at the next edge for clear); the next write and read return the new data.
